// File: rtl/ram_stream_if.sv
// ram_stream_if: stream/bus bundle for ram_stream.
//   master modport: drives write1_read0, in_valid, data_in; observes the
//                   read data, pointers and event pulses.
//   slave modport : the ram_stream side (inputs/outputs mirrored).
// Parameters must match those of the ram_stream instance it connects to.
interface ram_stream_if #(
    parameter int DATA_W = 16,
    parameter int WORDS  = 256,
    parameter int PAGES  = 32
);
    localparam int WA_W = $clog2(WORDS);
    localparam int PA_W = $clog2(PAGES);

    logic              write1_read0;  // 1 = write stream, 0 = read stream
    logic              in_valid;      // write beat / read request
    logic [DATA_W-1:0] data_in;       // write data
    logic [DATA_W-1:0] data_out;      // registered read data
    logic              out_valid;     // data_out valid pulse
    logic [PA_W-1:0]   page_addr;     // current page pointer
    logic [WA_W-1:0]   word_count;    // current word pointer within page
    logic              status_change; // pulse after an accepted mode change
    logic              page_done;     // pulse after the last word of a page
    logic              wrap;          // pulse when page_addr wraps to 0

    modport master (
        output write1_read0, in_valid, data_in,
        input  data_out, out_valid, page_addr, word_count,
               status_change, page_done, wrap
    );

    modport slave (
        input  write1_read0, in_valid, data_in,
        output data_out, out_valid, page_addr, word_count,
               status_change, page_done, wrap
    );
endinterface

// File: rtl/ram_stream.sv
// ram_stream: paged single-port RAM accessed as a write stream or a read
// stream. Each accepted beat uses the location {page_addr, word_count} and
// then advances the pointer pair; a mode change restarts at address 0.
//   clock : sole clock, rising edge
//   reset : asynchronous, active-high; clears control state, not the RAM
//   bus   : ram_stream_if.slave (mode, beat qualifier, data, pointers, pulses)
module ram_stream #(
    parameter int DATA_W = 16,
    parameter int WORDS  = 256,
    parameter int PAGES  = 32
) (
    input  logic         clock,
    input  logic         reset,
    ram_stream_if.slave  bus
);
    localparam int WA_W  = $clog2(WORDS);
    localparam int PA_W  = $clog2(PAGES);
    localparam int TOTAL = WORDS * PAGES;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ
    } state_t;

    state_t            state, state_next;
    logic              last_mode, last_mode_next;
    logic              mode_change;
    logic              beat;
    logic              write_beat, read_beat;
    logic              last_word, last_page;

    logic [PA_W-1:0]   page_addr;
    logic [WA_W-1:0]   word_count;
    logic [DATA_W-1:0] data_out;
    logic              out_valid, status_change, page_done, wrap;

    logic [DATA_W-1:0] mem [TOTAL];

    // Next-state / beat qualification.
    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_next     = state;
        last_mode_next = last_mode;
        mode_change    = 1'b0;
        beat           = 1'b0;
        case (state)
            IDLE: begin
                // Leave IDLE on the first edge after reset; never accept a beat here.
                state_next     = bus.write1_read0 ? WRITE : READ;
                last_mode_next = bus.write1_read0;
            end
            WRITE, READ: begin
                if (bus.write1_read0 != last_mode) begin
                    // A beat coincident with a mode change is dropped.
                    mode_change    = 1'b1;
                    state_next     = bus.write1_read0 ? WRITE : READ;
                    last_mode_next = bus.write1_read0;
                end else begin
                    beat = bus.in_valid;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign write_beat = beat && (state == WRITE);
    assign read_beat  = beat && (state == READ);
    assign last_word  = (word_count == WA_W'(WORDS - 1));
    assign last_page  = (page_addr == PA_W'(PAGES - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            last_mode     <= 1'b0;
            page_addr     <= '0;
            word_count    <= '0;
            data_out      <= '0;
            out_valid     <= 1'b0;
            status_change <= 1'b0;
            page_done     <= 1'b0;
            wrap          <= 1'b0;
        end else begin
            state         <= state_next;
            last_mode     <= last_mode_next;
            status_change <= mode_change;
            out_valid     <= read_beat;
            page_done     <= beat && last_word;
            wrap          <= beat && last_word && last_page;

            if (mode_change) begin
                page_addr  <= '0;
                word_count <= '0;
            end else if (beat) begin
                // Power-of-two field widths give the modulo wrap for free.
                word_count <= word_count + 1'b1;
                if (last_word) begin
                    page_addr <= page_addr + 1'b1;
                end
            end

            if (read_beat) begin
                data_out <= mem[{page_addr, word_count}];
            end
        end
    end

    // NOTE: the RAM array has no reset so it maps onto block RAM and keeps its
    // contents across a reset. While reset is high the FSM is held in IDLE,
    // so write_beat is low and an interrupted beat never reaches the array.
    always_ff @(posedge clock) begin
        if (write_beat) begin
            mem[{page_addr, word_count}] <= bus.data_in;
        end
    end

    assign bus.data_out      = data_out;
    assign bus.out_valid     = out_valid;
    assign bus.page_addr     = page_addr;
    assign bus.word_count    = word_count;
    assign bus.status_change = status_change;
    assign bus.page_done     = page_done;
    assign bus.wrap          = wrap;
endmodule

// File: tb/tb_ram_stream.sv
// tb_ram_stream: directed scenarios plus randomized traffic for ram_stream
// (WORDS=4, PAGES=2, DATA_W=16), checked cycle by cycle against a model that
// treats the RAM as a flat array walked by one linear pointer.
module tb_ram_stream;
    localparam int DATA_W = 16;
    localparam int WORDS  = 4;
    localparam int PAGES  = 2;
    localparam int TOTAL  = WORDS * PAGES;

    logic clock;
    logic reset;

    ram_stream_if #(.DATA_W(DATA_W), .WORDS(WORDS), .PAGES(PAGES)) bus ();

    ram_stream #(.DATA_W(DATA_W), .WORDS(WORDS), .PAGES(PAGES)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit                m_idle;
    bit                m_mode;
    int                m_ptr;
    logic [DATA_W-1:0] m_mem [TOTAL];
    bit                m_written [TOTAL];
    logic [DATA_W-1:0] m_data;
    bit                m_data_known;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input bit e_sc, input bit e_ov, input bit e_pd, input bit e_wr);
        check("status_change", 32'(bus.status_change), 32'(e_sc));
        check("out_valid",     32'(bus.out_valid),     32'(e_ov));
        check("page_done",     32'(bus.page_done),     32'(e_pd));
        check("wrap",          32'(bus.wrap),          32'(e_wr));
        check("page_addr",     32'(bus.page_addr),     32'(m_ptr / WORDS));
        check("word_count",    32'(bus.word_count),    32'(m_ptr % WORDS));
        if (m_data_known) check("data_out", 32'(bus.data_out), 32'(m_data));
    endtask

    // One clock cycle: present inputs, let the edge happen, predict and compare.
    task automatic step(input bit wr, input bit vld, input logic [DATA_W-1:0] din);
        bit e_sc, e_ov, e_pd, e_wr;
        @(negedge clock);
        bus.write1_read0 = wr;
        bus.in_valid     = vld;
        bus.data_in      = din;
        @(posedge clock);
        #1;
        e_sc = 0; e_ov = 0; e_pd = 0; e_wr = 0;
        if (m_idle) begin
            m_idle = 0;
            m_mode = wr;
        end else if (wr != m_mode) begin
            m_mode = wr;
            m_ptr  = 0;
            e_sc   = 1;
        end else if (vld) begin
            if (wr) begin
                m_mem[m_ptr]     = din;
                m_written[m_ptr] = 1;
            end else begin
                e_ov         = 1;
                m_data       = m_mem[m_ptr];
                m_data_known = m_written[m_ptr];
            end
            e_pd  = (m_ptr % WORDS) == WORDS - 1;
            e_wr  = (m_ptr == TOTAL - 1);
            m_ptr = (m_ptr + 1) % TOTAL;
        end
        check_outputs(e_sc, e_ov, e_pd, e_wr);
    endtask

    // Assert reset between edges with a beat presented alongside it; outputs
    // must clear at once and the beat must leave the RAM untouched.
    task automatic do_reset(input int cycles, input bit wr, input bit vld, input logic [DATA_W-1:0] din);
        @(negedge clock);
        bus.write1_read0 = wr;
        bus.in_valid     = vld;
        bus.data_in      = din;
        reset            = 1'b1;
        #1;
        m_idle       = 1;
        m_mode       = 0;
        m_ptr        = 0;
        m_data       = '0;
        m_data_known = 1;
        check_outputs(0, 0, 0, 0);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            #1;
            check_outputs(0, 0, 0, 0);
        end
        reset = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        bus.write1_read0 = 1'b0;
        bus.in_valid     = 1'b0;
        bus.data_in      = '0;
        for (int i = 0; i < TOTAL; i++) m_written[i] = 0;
        do_reset(2, 0, 0, 16'h0000);

        // Fill both pages, then read them back; page_done/wrap land on beats 4 and 8.
        step(1, 0, 16'h0000);
        for (int i = 0; i < 8; i++) step(1, 1, 16'(16'h1000 + i));
        step(0, 0, 16'h0000);
        for (int i = 0; i < 8; i++) step(0, 1, 16'h0000);
        step(0, 0, 16'h0000);

        // Beats coincident with mode toggles are dropped.
        do_reset(1, 0, 0, 16'h0000);
        step(1, 0, 16'h0000);
        step(1, 1, 16'hA5A5);
        step(0, 1, 16'hDEAD);
        step(1, 1, 16'hDEAD);
        step(0, 1, 16'hDEAD);
        step(0, 1, 16'h0000);

        // Mid-stream reset with a write beat pending; RAM contents survive.
        do_reset(1, 0, 0, 16'h0000);
        step(1, 0, 16'h0000);
        for (int i = 0; i < 3; i++) step(1, 1, 16'(16'h3000 + i));
        do_reset(2, 1, 1, 16'hBEEF);
        step(0, 0, 16'h0000);
        for (int i = 0; i < 4; i++) step(0, 1, 16'h0000);

        // Read requests on alternate cycles; data_out holds between pulses.
        for (int i = 0; i < 10; i++) step(0, (i % 2) == 0, 16'h0000);

        // Randomized traffic with occasional mode flips and resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset($urandom_range(1, 2), 1'($urandom), 1'($urandom), 16'($urandom));
            end else begin
                bit wr;
                wr = ($urandom_range(0, 9) == 0) ? ~m_mode : m_mode;
                if (m_idle) wr = 1'($urandom);
                step(wr, $urandom_range(0, 3) != 0, 16'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
